// File: rtl/vram_arb_pkg.sv
// Shared types and counter widths for the VRAM arbiter.
package vram_arb_pkg;

  // Access sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Arbitration winner.
  typedef enum logic {
    GNT_MPU = 1'b0,
    GNT_GFX = 1'b1
  } grant_e;

  // Parameter maxima; counter widths are sized for these so any legal setting fits.
  localparam int unsigned WaitStatesMax = 7;
  localparam int unsigned MpuMaxWaitMax = 15;
  localparam int unsigned WaitCntW      = $clog2(WaitStatesMax + 1);
  localparam int unsigned StarveCntW    = $clog2(MpuMaxWaitMax + 1);

endpackage

// File: rtl/vram_arb_select.sv
// Winner selection for the VRAM arbiter: graphics has priority, but the MPU is
// forced through once it has lost MPU_MAX_WAIT consecutive arbitrations.
module vram_arb_select
  import vram_arb_pkg::*;
#(
  parameter int unsigned MPU_MAX_WAIT = 4
) (
  input  logic   i_clk,
  input  logic   i_reset,
  input  logic   i_arb_en,   // high in IDLE, when the grant is actually consumed
  input  logic   i_mpu_req,
  input  logic   i_gfx_req,
  output logic   o_any_req,
  output grant_e o_grant
);

  logic [StarveCntW-1:0] r_starve;
  logic                  w_starved;

  assign w_starved = (r_starve == StarveCntW'(MPU_MAX_WAIT));

  // Combinational winner; only meaningful when o_any_req is high.
  always_comb begin
    o_any_req = i_mpu_req | i_gfx_req;
    o_grant   = GNT_GFX;
    if (i_mpu_req && (!i_gfx_req || w_starved)) begin
      o_grant = GNT_MPU;
    end
  end

  // Starvation counter: counts MPU losses, saturating; clears on MPU win or MPU idle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_starve <= '0;
    end else if (i_arb_en) begin
      if (!i_mpu_req || (o_grant == GNT_MPU)) begin
        r_starve <= '0;
      end else if (!w_starved) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shares the external async VRAM between the MPU bridge and the graphics fetch
// port. Each access runs IDLE -> ACCESS (1 + WAIT_STATES cycles) -> DONE, where
// DONE is a bus-turnaround cycle carrying the winner's one-cycle ack.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned WAIT_STATES  = 1,
  parameter int unsigned MPU_MAX_WAIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_mpu_req,
  input  logic                  i_mpu_wr,
  input  logic [1:0]            i_mpu_be,
  input  logic [ADDR_WIDTH-1:0] i_mpu_addr,
  input  logic [DATA_WIDTH-1:0] i_mpu_wdata,
  output logic                  o_mpu_ack,
  output logic [DATA_WIDTH-1:0] o_mpu_rdata,
  input  logic                  i_gfx_req,
  input  logic [ADDR_WIDTH-1:0] i_gfx_addr,
  output logic                  o_gfx_ack,
  output logic [DATA_WIDTH-1:0] o_gfx_rdata,
  output logic                  o_vram_en,
  output logic                  o_vram_rd,
  output logic                  o_vram_wr,
  output logic [1:0]            o_vram_be,
  output logic [ADDR_WIDTH-1:0] o_vram_addr,
  output logic [DATA_WIDTH-1:0] o_vram_data_out,
  input  logic [DATA_WIDTH-1:0] i_vram_data_in
);

  state_e                r_state;
  grant_e                r_gnt;
  logic [WaitCntW-1:0]   r_wait;
  logic                  r_mpu_ack;
  logic                  r_gfx_ack;
  logic [DATA_WIDTH-1:0] r_mpu_rdata;
  logic [DATA_WIDTH-1:0] r_gfx_rdata;
  // The vram_* output registers double as the latched copy of the winner's fields,
  // so requester field changes after the grant cannot disturb the access.
  logic                  r_vram_en;
  logic                  r_vram_rd;
  logic                  r_vram_wr;
  logic [1:0]            r_vram_be;
  logic [ADDR_WIDTH-1:0] r_vram_addr;
  logic [DATA_WIDTH-1:0] r_vram_data_out;

  logic                  w_arb_en;
  logic                  w_any_req;
  grant_e                w_grant;

  assign w_arb_en = (r_state == IDLE);

  vram_arb_select #(
    .MPU_MAX_WAIT (MPU_MAX_WAIT)
  ) u_select (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_arb_en  (w_arb_en),
    .i_mpu_req (i_mpu_req),
    .i_gfx_req (i_gfx_req),
    .o_any_req (w_any_req),
    .o_grant   (w_grant)
  );

  // Access sequencer with registered bus strobes, acks and read-data capture.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= IDLE;
      r_gnt           <= GNT_GFX;
      r_wait          <= '0;
      r_mpu_ack       <= 1'b0;
      r_gfx_ack       <= 1'b0;
      r_mpu_rdata     <= '0;
      r_gfx_rdata     <= '0;
      r_vram_en       <= 1'b0;
      r_vram_rd       <= 1'b0;
      r_vram_wr       <= 1'b0;
      r_vram_be       <= '0;
      r_vram_addr     <= '0;
      r_vram_data_out <= '0;
    end else begin
      // Acks are single-cycle pulses; only the ACCESS exit raises one.
      r_mpu_ack <= 1'b0;
      r_gfx_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state   <= ACCESS;
            r_gnt     <= w_grant;
            r_wait    <= WaitCntW'(WAIT_STATES);
            r_vram_en <= 1'b1;
            if (w_grant == GNT_MPU) begin
              r_vram_rd       <= ~i_mpu_wr;
              r_vram_wr       <= i_mpu_wr;
              r_vram_be       <= i_mpu_be;
              r_vram_addr     <= i_mpu_addr;
              r_vram_data_out <= i_mpu_wdata;
            end else begin
              r_vram_rd       <= 1'b1;
              r_vram_wr       <= 1'b0;
              r_vram_be       <= 2'b11;
              r_vram_addr     <= i_gfx_addr;
              r_vram_data_out <= '0;
            end
          end
        end
        ACCESS: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - 1'b1;
          end else begin
            if (r_vram_rd) begin
              if (r_gnt == GNT_MPU) begin
                r_mpu_rdata <= i_vram_data_in;
              end else begin
                r_gfx_rdata <= i_vram_data_in;
              end
            end
            if (r_gnt == GNT_MPU) begin
              r_mpu_ack <= 1'b1;
            end else begin
              r_gfx_ack <= 1'b1;
            end
            // Turnaround: release the bus completely for the DONE cycle.
            r_vram_en       <= 1'b0;
            r_vram_rd       <= 1'b0;
            r_vram_wr       <= 1'b0;
            r_vram_be       <= '0;
            r_vram_addr     <= '0;
            r_vram_data_out <= '0;
            r_state         <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_mpu_ack       = r_mpu_ack;
  assign o_gfx_ack       = r_gfx_ack;
  assign o_mpu_rdata     = r_mpu_rdata;
  assign o_gfx_rdata     = r_gfx_rdata;
  assign o_vram_en       = r_vram_en;
  assign o_vram_rd       = r_vram_rd;
  assign o_vram_wr       = r_vram_wr;
  assign o_vram_be       = r_vram_be;
  assign o_vram_addr     = r_vram_addr;
  assign o_vram_data_out = r_vram_data_out;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single external 16-bit async VRAM between two requesters: the MPU port (SPI memory bridge) and the graphics fetch port (renderer line/tile fetch).
- Sequences each access: grant, address/control phase with configurable wait states, data capture, turnaround, acknowledge.
- Sits inside the core between the MPU bus, the renderer, and the top-level VRAM pins, which are inverted to active-low outside this block.
- Graphics has priority; a starvation counter bounds MPU wait.

Parameters:
- ADDR_WIDTH, 16, VRAM word address width.
- DATA_WIDTH, 16, VRAM data width.
- WAIT_STATES, 1, extra ACCESS cycles beyond the first (range 0..7).
- MPU_MAX_WAIT, 4, consecutive lost arbitrations before the MPU is forced to win (range 1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mpu_req  in  1  MPU access request; hold with fields stable until mpu_ack
- mpu_wr  in  1  1=write, 0=read
- mpu_be  in  2  byte enables, active high
- mpu_addr  in  ADDR_WIDTH  word address
- mpu_wdata  in  DATA_WIDTH  write data
- mpu_ack  out  1  one-cycle completion pulse
- mpu_rdata  out  DATA_WIDTH  read data, valid from the mpu_ack cycle until the next MPU read completes
- gfx_req  in  1  graphics read request (read-only, both bytes)
- gfx_addr  in  ADDR_WIDTH  word address
- gfx_ack  out  1  one-cycle completion pulse
- gfx_rdata  out  DATA_WIDTH  read data, held like mpu_rdata
- vram_en  out  1  VRAM enable (internally active high)
- vram_rd  out  1  read strobe
- vram_wr  out  1  write strobe
- vram_be  out  2  byte enables
- vram_addr  out  ADDR_WIDTH  address
- vram_data_out  out  DATA_WIDTH  write data; pad tristate is enabled only when vram_en & vram_wr
- vram_data_in  in  DATA_WIDTH  data from pad

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). All outputs are registered.
- Reset values:
  - State IDLE.
  - All vram_* outputs, mpu_ack, gfx_ack and both rdata registers are 0.
  - Starvation counter is 0.
- States:
  - IDLE: arbitrate. If any request is pending, latch the winner's addr/be/wr/wdata and go to ACCESS with wait counter = WAIT_STATES.
  - ACCESS: vram_en=1 and vram_addr/vram_be from the latched fields. vram_rd=~wr, vram_wr=wr, vram_data_out=latched wdata. Gfx accesses use be=2'b11 and rd=1.
    - While the wait counter is nonzero: decrement and stay.
    - When it is 0: for a read, capture vram_data_in into the winner's rdata register; then go to DONE.
  - DONE: all vram_* deasserted (bus turnaround); pulse the winner's ack for exactly this cycle; go to IDLE.
- Latency:
  - Request seen in IDLE at cycle N.
  - ACCESS occupies cycles N+1 .. N+1+WAIT_STATES.
  - ack at N+2+WAIT_STATES.
  - Next sample in IDLE at N+3+WAIT_STATES.
  - With WAIT_STATES=1: ack at N+3, 4-cycle throughput per access.
- Handshake:
  - A requester may present a new request in the cycle after its ack by keeping req high with new fields.
  - To stop, the requester drops req in the cycle after ack.
  - Changing fields while waiting, before ack, is illegal. The latched copy makes the access immune to such changes.
- Arbitration (IDLE only):
  - Only one request pending: that requester wins.
  - Both pending: gfx wins, unless the starvation counter equals MPU_MAX_WAIT, in which case the MPU wins.
- Starvation counter:
  - Increments (saturating at MPU_MAX_WAIT) on each IDLE arbitration where mpu_req=1 and gfx wins.
  - Clears on an MPU grant, or in any IDLE cycle with mpu_req=0.
- Writes leave both rdata registers unchanged.
- A read leaves the other requester's rdata unchanged.
- Requests arriving during ACCESS/DONE wait. They are never dropped and never acknowledged twice.
- Reset mid-access: the next cycle is IDLE, strobes are deasserted, and no ack is issued for the aborted access.

Decomposition:
- Shared package vram_arb_pkg:
  - State enum {IDLE, ACCESS, DONE}.
  - Grant enum {GNT_MPU, GNT_GFX}.
  - Wait-counter and starvation-counter widths derived from the parameter maxima.
- One sub-module, vram_arb_select: combinational winner selection plus the registered starvation counter. The FSM and datapath latches stay in vram_arbiter.

Test Plan:
- MPU read alone, WAIT_STATES=1, addr 0x1234, vram_data_in=0xBEEF during ACCESS -> vram_en/rd high cycles N+1..N+2, mpu_ack pulse at N+3, mpu_rdata=0xBEEF, gfx_rdata stays 0.
- MPU write addr 0x0010, be=2'b10, wdata 0xA55A -> vram_wr=1, vram_be=2'b10, vram_data_out=0xA55A for 2 cycles; DONE cycle has all strobes 0; mpu_rdata unchanged.
- gfx_req and mpu_req held continuously, MPU_MAX_WAIT=4 -> grant order GFX,GFX,GFX,GFX,MPU, repeating; every ack exactly one cycle.
- Back-to-back gfx reads to 0x0100 then 0x0101 with req held and addr updated after ack -> second ACCESS starts 4 cycles after the first; both rdata values are correct.
- reset asserted during the second ACCESS cycle of an MPU read -> next cycle IDLE with all outputs 0; no mpu_ack; a re-issued request completes normally.
- WAIT_STATES=0 and WAIT_STATES=3 -> ack at N+2 and N+5 respectively.
